fifo_stream_out: RTL and testbench

FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

---
 rtl/fifo_stream_out.sv | 114 +++++++++++
 tb/tb_fifo_stream_out.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Output stage from a FIFO controller to a valid/ready stream.
// A two-entry head/skid buffer keeps the FIFO pop independent of m_ready.
module fifo_stream_out #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  fifo_empty,
   output logic                  fifo_rd,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [CNT_WIDTH-1:0]  beat_cnt
);

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   occ_e                  occ_q, occ_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  m_valid_q, m_valid_d;
   logic                  push_s;
   logic                  pop_s;

   // Pop the FIFO only while a free slot is guaranteed, so m_ready never reaches fifo_rd.
   assign push_s  = ~fifo_empty & (occ_q != OCC_TWO) & ~flush & ~reset;
   assign pop_s   = m_valid_q & m_ready;
   assign fifo_rd = push_s;

   assign m_valid  = m_valid_q;
   assign m_data   = head_q;
   assign beat_cnt = cnt_q;

   // Next-state for occupancy, buffer registers and the beat counter.
   always_comb begin
      occ_d  = occ_q;
      head_d = head_q;
      skid_d = skid_q;
      cnt_d  = cnt_q;
      if (flush) begin
         occ_d = OCC_EMPTY;
      end else begin
         if (pop_s) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
         case (occ_q)
            OCC_EMPTY: begin
               if (push_s) begin
                  head_d = fifo_rdata;
                  occ_d  = OCC_ONE;
               end else begin
                  occ_d  = OCC_EMPTY;
               end
            end
            OCC_ONE: begin
               if (push_s && pop_s) begin
                  head_d = fifo_rdata;
                  occ_d  = OCC_ONE;
               end else if (push_s) begin
                  skid_d = fifo_rdata;
                  occ_d  = OCC_TWO;
               end else if (pop_s) begin
                  occ_d  = OCC_EMPTY;
               end else begin
                  occ_d  = OCC_ONE;
               end
            end
            OCC_TWO: begin
               // No push can happen here; the skid word moves up on a pop.
               if (pop_s) begin
                  head_d = skid_q;
                  occ_d  = OCC_ONE;
               end else begin
                  occ_d  = OCC_TWO;
               end
            end
            default: begin
               occ_d = OCC_EMPTY;
            end
         endcase
      end
      m_valid_d = (occ_d != OCC_EMPTY);
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ_q     <= OCC_EMPTY;
         head_q    <= {DATA_WIDTH{1'b0}};
         skid_q    <= {DATA_WIDTH{1'b0}};
         cnt_q     <= {CNT_WIDTH{1'b0}};
         m_valid_q <= 1'b0;
      end else begin
         occ_q     <= occ_d;
         head_q    <= head_d;
         skid_q    <= skid_d;
         cnt_q     <= cnt_d;
         m_valid_q <= m_valid_d;
      end
   end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Bench for fifo_stream_out: queue-based model, per-cycle compare, directed scenarios.
`timescale 1ns/1ps
module tb_fifo_stream_out;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, flush, fifo_empty, m_ready, gate;
   logic [7:0]  fifo_rdata;
   logic        fifo_rd, m_valid, fifo_rd4, m_valid4;
   logic [7:0]  m_data, m_data4;
   logic [15:0] beat_cnt;
   logic [3:0]  beat_cnt4;

   fifo_stream_out #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty),
      .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .beat_cnt(beat_cnt));

   fifo_stream_out #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty),
      .fifo_rd(fifo_rd4), .fifo_rdata(fifo_rdata), .m_valid(m_valid4),
      .m_ready(m_ready), .m_data(m_data4), .beat_cnt(beat_cnt4));

   int checks = 0;
   int errors = 0;

   logic [7:0] src[$];
   logic [7:0] mq[$];
   logic [7:0] got[$];
   logic [7:0] sent[$];
   logic [7:0] acc[$];
   int         acc_step[$];

   logic        exp_valid, exp_rd;
   logic [7:0]  exp_data;
   logic [31:0] exp_cnt = 32'd0;
   bit          chk_en = 1'b0;
   int          rd_hi = 0;
   int          step_no = 0;
   logic        stall_r = 1'b0;
   logic [7:0]  stall_data_r = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
         chk("fifo_rd", {31'd0, fifo_rd}, {31'd0, exp_rd});
         chk("beat_cnt", {16'd0, beat_cnt}, {16'd0, exp_cnt[15:0]});
         chk("m_valid4", {31'd0, m_valid4}, {31'd0, exp_valid});
         chk("fifo_rd4", {31'd0, fifo_rd4}, {31'd0, exp_rd});
         chk("beat_cnt4", {28'd0, beat_cnt4}, {28'd0, exp_cnt[3:0]});
         if (exp_valid) begin
            chk("m_data", {24'd0, m_data}, {24'd0, exp_data});
            chk("m_data4", {24'd0, m_data4}, {24'd0, exp_data});
         end
         if (stall_r) begin
            chk("stall_valid", {31'd0, m_valid}, 32'd1);
            chk("stall_data", {24'd0, m_data}, {24'd0, stall_data_r});
         end
         stall_r      = m_valid && !m_ready && !reset && !flush;
         stall_data_r = m_data;
      end
   end

   task automatic step(input logic rst, input logic fl, input logic rdy, input logic gt);
      reset      = rst;
      flush      = fl;
      m_ready    = rdy;
      gate       = gt;
      fifo_empty = gt || (src.size() == 0);
      fifo_rdata = (src.size() != 0) ? src[0] : 8'h00;
      exp_valid  = (mq.size() != 0);
      exp_data   = exp_valid ? mq[0] : 8'h00;
      exp_rd     = !fifo_empty && (mq.size() < 2) && !fl && !rst;
      @(negedge clk);
      rd_hi += int'(fifo_rd);
      if (m_valid && m_ready) begin
         acc.push_back(m_data);
         acc_step.push_back(step_no);
      end
      step_no++;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         exp_cnt = 32'd0;
      end else if (fl) begin
         mq.delete();
      end else begin
         if (exp_valid && rdy) begin
            got.push_back(mq.pop_front());
            exp_cnt++;
         end
         if (exp_rd) mq.push_back(fifo_rdata);
      end
      if (exp_rd) void'(src.pop_front());
      #1;
   endtask

   initial begin
      logic [7:0] t2[3];
      logic [7:0] w;
      int base, nmis, budget;
      t2 = '{8'h11, 8'h22, 8'h33};
      reset = 1'b1; flush = 1'b0; m_ready = 1'b0; gate = 1'b0;
      fifo_empty = 1'b1; fifo_rdata = 8'h00;
      #1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_cnt", {16'd0, beat_cnt}, 32'd0);

      // Idle with an empty FIFO.
      rd_hi = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle_rd_hi", rd_hi, 32'd0);
      chk("idle_cnt", {16'd0, beat_cnt}, 32'd0);

      // Three words, sink always ready.
      rd_hi = 0; acc.delete(); acc_step.delete();
      src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
      base = step_no;
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t2_rd_hi", rd_hi, 32'd3);
      chk("t2_cnt", {16'd0, beat_cnt}, 32'd3);
      chk("t2_nacc", acc.size(), 32'd3);
      for (int i = 0; i < 3 && i < acc.size(); i++) begin
         chk("t2_data", {24'd0, acc[i]}, {24'd0, t2[i]});
         chk("t2_step", acc_step[i], base + 1 + i);
      end

      // Blocked sink: two pops only, then drain without gaps.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      src.delete(); rd_hi = 0;
      for (int i = 0; i < 5; i++) src.push_back(8'hA0 + 8'(i));
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_rd_hi", rd_hi, 32'd2);
      chk("t3_hold", {24'd0, m_data}, 32'h0000_00A0);
      chk("t3_valid", {31'd0, m_valid}, 32'd1);
      acc.delete(); acc_step.delete();
      base = step_no;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_nacc", acc.size(), 32'd5);
      for (int i = 0; i < 5 && i < acc.size(); i++) begin
         chk("t3_data", {24'd0, acc[i]}, 32'h0000_00A0 + i);
         chk("t3_step", acc_step[i], base + i);
      end

      // Flush while holding two words, then flush while holding one.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      src.delete();
      src.push_back(8'h5A); src.push_back(8'h5B);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4_head", {24'd0, m_data}, 32'h0000_005A);
      src.push_back(8'h5C);
      rd_hi = 0;
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("t4_rd_flush", rd_hi, 32'd0);
      chk("t4_valid", {31'd0, m_valid}, 32'd0);
      chk("t4_cnt", {16'd0, beat_cnt}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      src.push_back(8'h5D);
      rd_hi = 0;
      step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4b_rd_flush", rd_hi, 32'd0);
      chk("t4b_valid", {31'd0, m_valid}, 32'd0);

      // Counter wrap on the 4-bit instance, then reset mid-stream.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      src.delete();
      for (int i = 0; i < 17; i++) src.push_back(8'h40 + 8'(i));
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("t5_cnt4", {28'd0, beat_cnt4}, 32'd1);
      chk("t5_cnt16", {16'd0, beat_cnt}, 32'd17);
      for (int i = 0; i < 6; i++) src.push_back(8'hC0 + 8'(i));
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk("t5_rst_valid", {31'd0, m_valid}, 32'd0);
      chk("t5_rst_cnt", {16'd0, beat_cnt}, 32'd0);
      chk("t5_rst_cnt4", {28'd0, beat_cnt4}, 32'd0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5_post_head", {24'd0, m_data}, 32'h0000_00C2);

      // Random stalls on both sides, 1000 words.
      step(1'b1, 1'b0, 1'b0, 1'b0);
      src.delete(); sent.delete(); got.delete(); acc.delete(); acc_step.delete();
      for (int i = 0; i < 1000; i++) begin
         w = 8'($urandom);
         src.push_back(w);
         sent.push_back(w);
      end
      budget = 0;
      while (acc.size() < 1000 && budget < 8000) begin
         step(1'b0, 1'b0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
         budget++;
      end
      chk("t6_nacc", acc.size(), 32'd1000);
      nmis = 0;
      for (int i = 0; i < 1000 && i < acc.size(); i++) begin
         if (acc[i] !== sent[i]) nmis++;
      end
      chk("t6_order", nmis, 32'd0);
      chk("t6_cnt", {16'd0, beat_cnt}, 32'd1000);
      chk("t6_cnt4", {28'd0, beat_cnt4}, 32'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
